// File: rtl/uart_rx_frame.sv
// UART receive front end: 2-flop synchroniser, 3-sample majority voting, one-entry holding buffer.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects the sense).
module uart_rx_frame #(
    parameter int SYS_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = SYS_FREQ / (BAUD_RATE * OVERSAMPLE),
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 recv_req,
    input  logic                 recv_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DW  = $clog2(TICK_DIV + 1);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2 - 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_S0      = TW'(MID - 1);
    localparam logic [TW-1:0] T_S1      = TW'(MID);
    localparam logic [TW-1:0] T_S2      = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || TICK_DIV < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;
    logic                 fe_pend;
    logic                 tick, last_smp, bit_end, maj;
    logic                 start_go, shift_en, stop_smp, frame_done;
`ifdef UART_RX_PARITY_EN
    localparam logic P_ODD = (PARITY_ODD != 0);
    logic                 par_smp, pe_pend, pe_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rx_s, rx_meta} <= 2'b11;
        else          {rx_s, rx_meta} <= {rx_meta, rx};
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign last_smp = tick && (tick_cnt == T_S2);
    assign bit_end  = tick && (tick_cnt == T_LAST);
    // Majority of the two earlier window samples and the live third one.
    assign maj = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            samp     <= '0;
        end else begin
            if (start_go || tick) div_cnt <= '0;
            else                  div_cnt <= div_cnt + DW'(1);

            if (start_go)     tick_cnt <= '0;
            else if (tick)    tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);

            if (tick && (tick_cnt == T_S0 || tick_cnt == T_S1))
                samp <= {samp[0], rx_s};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tick && !rx_s && armed) state_nxt = START;
            START: begin
                if (last_smp && maj) state_nxt = IDLE;
                else if (bit_end)    state_nxt = DATA;
            end
            DATA: if (bit_end && bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) state_nxt = STOP;
`endif
            STOP:  if (last_smp && bit_cnt == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_go   = 1'b0;
        shift_en   = 1'b0;
        stop_smp   = 1'b0;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp    = 1'b0;
`endif
        case (state)
            IDLE: start_go = tick && !rx_s && armed;
            DATA: shift_en = last_smp;
`ifdef UART_RX_PARITY_EN
            PARITY: par_smp = last_smp;
`endif
            STOP: begin
                stop_smp   = last_smp;
                frame_done = last_smp && (bit_cnt == STOP_LAST);
            end
            default: ;
        endcase
    end

    // armed holds off a new START after a break until the line is seen idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
            fe_pend <= 1'b0;
        end else begin
            if (state_nxt != state)
                bit_cnt <= '0;
            else if (bit_end && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (start_go)                       armed <= 1'b0;
            else if (state == IDLE && tick && rx_s) armed <= 1'b1;

            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};

            if (start_go)              fe_pend <= 1'b0;
            else if (stop_smp && !maj) fe_pend <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     pe_pend <= 1'b0;
        else if (start_go) pe_pend <= 1'b0;
        else if (par_smp)  pe_pend <= maj ^ (^shreg) ^ P_ODD;
    end
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    // A completing frame loads when the buffer is empty or being acked this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout      <= '0;
            recv_req  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!recv_req || recv_ack) begin
                    dout      <= shreg;
                    frame_err <= fe_pend | ~maj;
                    recv_req  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    pe_q      <= pe_pend;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (recv_ack) begin
                recv_req <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receive front end and next generation of the team's fixed 8N1 receiver.
- Adds configurable data width, stop bits and parity, plus an rx input synchroniser.
- Adds 3-sample majority mid-bit sampling, false-start rejection, framing/parity/overrun status, and a one-entry holding buffer so reception continues while the consumer has not acknowledged.
- Sits between the serial pin and the host-side req/ack consumer.

Parameters:
- SYS_FREQ, 50000000, clk frequency in Hz.
- BAUD_RATE, 9600, line rate in baud.
- OVERSAMPLE, 16, ticks per bit; even, ≥8.
- TICK_DIV, SYS_FREQ/(BAUD_RATE*OVERSAMPLE), clk cycles per oversample tick; must be ≥1.
- DATA_BITS, 8, data bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- PARITY_ODD, 0, 0 = even, 1 = odd; used only with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  asynchronous serial line; idle high
- dout  out  DATA_BITS  received word, LSB first on line
- recv_req  out  1  holding register valid
- recv_ack  in  1  consumer accept
- frame_err  out  1  stop bit sampled low for the held word
- parity_err  out  1  parity mismatch for the held word
- overrun  out  1  one-clk pulse: a completed frame was dropped

Behaviour:
- Reset is asynchronous, active-low, on reset_n. Clock is clk.
- Reset values: dout = 0, recv_req = 0, frame_err = 0, parity_err = 0, overrun = 0, state = IDLE, synchroniser = 2'b11, all counters 0.
- rx passes through a 2-flop synchroniser (rx_s). All checks use rx_s.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick asserts when the count equals TICK_DIV-1.
  - Tick count is reset to 0 on entry to START, so sampling phase aligns to the detected edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 on a tick -> START with tick_cnt = 0.
  - START: at tick_cnt = OVERSAMPLE/2-1, the majority of rx_s at ticks mid-1, mid, mid+1 decides. Majority 1 -> false start, back to IDLE, nothing reported. Majority 0 -> DATA with bit_cnt = 0.
  - DATA: each bit takes OVERSAMPLE ticks. The bit value is the majority of the 3 samples centred at mid-bit. It shifts into the MSB of the shift register (LSB-first line order). After DATA_BITS bits -> PARITY if the macro is enabled, else STOP.
  - PARITY: one bit period, majority-sampled; the result is stored as a pending parity error.
  - STOP: STOP_BITS periods. Any stop sample with majority 0 sets a pending frame error. After the final stop sample -> IDLE and frame complete.
- Frame complete, in the same cycle as the final stop sample:
  - recv_req = 0: dout, frame_err and parity_err load from the shift register and pending flags. recv_req rises on the next clk.
  - recv_req = 1 and recv_ack = 0: the held word is kept, the new frame is discarded, and overrun pulses high for exactly one clk.
  - recv_req = 1 and recv_ack = 1 in the same cycle: the ack is consumed and the new word loads. recv_req stays 1 with no overrun.
- Handshake:
  - recv_req stays high until recv_ack is sampled high; it drops on the following clk.
  - dout and the flags are stable while recv_req = 1.
  - recv_ack while recv_req = 0 is ignored.
- A false start or framing error does not stall. The FSM returns to IDLE and waits for rx_s high-to-low. A frame with frame_err is still delivered.
- Break condition (line held low): one frame is delivered with dout = 0 and frame_err = 1. No new START until rx_s has been seen high on a tick.
- Reset mid-frame: everything clears immediately and any held word is lost.
- Latency: recv_req rises 1 clk after the last stop sample, about (1 + DATA_BITS + parity + STOP_BITS - 0.5) bit periods after the start edge, plus 2 clk of synchroniser delay.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: PARITY state is present. The parity bit is checked against the XOR of the data bits, inverted when PARITY_ODD = 1. parity_err reports a mismatch.
- Undefined: no PARITY state and no parity bit expected. parity_err is tied to 0, and PARITY_ODD is ignored.

Test Plan:
- Bench configuration for all scenarios: SYS_FREQ = 1600000, BAUD_RATE = 10000, OVERSAMPLE = 16 (TICK_DIV = 10, 160 clk per bit), DATA_BITS = 8, STOP_BITS = 1.
- Basic frame: send 8N1 0xA5 -> recv_req rises; dout = 8'hA5, frame_err = 0, parity_err = 0. Assert recv_ack one cycle -> recv_req = 0 on the next clk.
- False start: 40-clk low glitch on rx -> no recv_req, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing error: 0x55 with the stop bit driven low -> dout = 8'h55, frame_err = 1.
- Overrun: 0x11 not acked, then 0x22 sent -> dout stays 8'h11 and overrun pulses 1 clk. Ack, then 0x33 -> dout = 8'h33, no overrun.
- Ack coincident with a second frame completing: 0x44 held, ack asserted on the exact cycle 0x66 completes -> recv_req stays 1, dout = 8'h66, overrun = 0.
- With UART_RX_PARITY_EN, PARITY_ODD = 0: 0x07 with parity bit 1 -> parity_err = 0. Same frame with parity bit 0 -> parity_err = 1. Reset asserted mid-data -> all outputs 0 within the reset cycle.
